// File: rtl/dac_burst_gen_if.sv
// Valid/ready word stream from the burst generator to the DAC frame serializer.
interface dac_burst_gen_if #(
    parameter int unsigned SAMPLE_W = 8
);
    logic [SAMPLE_W-1:0] s_data;
    logic                s_ch;
    logic                s_valid;
    logic                s_ready;

    modport master (output s_data, output s_ch, output s_valid, input s_ready);
    modport slave  (input s_data, input s_ch, input s_valid, output s_ready);
endinterface

// File: rtl/dac_burst_gen.sv
// Phase-accumulator tone-burst generator emitting interleaved ch0/ch1 DAC codes,
// finishing every burst with a midscale park pair.
module dac_burst_gen #(
    parameter int unsigned PHASE_W  = 16,
    parameter int unsigned SAMPLE_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [PHASE_W-1:0] phase_inc,
    input  logic [7:0]         n_cycles,
    input  logic [1:0]         wave_sel,
    input  logic               ch_invert,
    dac_burst_gen_if.master    s,
    output logic               busy,
    output logic               done
);
    localparam int unsigned CNT_W = 8;
    localparam logic [SAMPLE_W-1:0] MIDSCALE = SAMPLE_W'(8'h80);

    typedef enum logic [2:0] {
        IDLE, EMIT0, EMIT1, PARK0, PARK1, FIN
    } state_t;

    state_t              state_q, state_d;
    logic [PHASE_W-1:0]  phase_q, phase_d;
    logic [PHASE_W-1:0]  inc_q, inc_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [CNT_W-1:0]    ncyc_q, ncyc_d;
    logic [1:0]          wave_q, wave_d;
    logic                inv_q, inv_d;
    logic [SAMPLE_W-1:0] data_q, data_d;
    logic                ch_q, ch_d;
    logic                valid_q, valid_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                xfer;
    logic [PHASE_W:0]    phase_sum;
    logic [7:0]          code;

    // Map the top 8 phase bits onto the selected waveform.
    function automatic logic [7:0] shape(input logic [1:0] w, input logic [7:0] p);
        logic [7:0] r;
        case (w)
            2'd0:    r = p[7] ? 8'h00 : 8'hFF;
            2'd1:    r = p[7] ? (8'hFF - {p[6:0], 1'b0}) : {p[6:0], 1'b0};
            2'd2:    r = p;
            default: r = 8'h80;
        endcase
        return r;
    endfunction

    assign xfer      = valid_q & s.s_ready;
    assign phase_sum = {1'b0, phase_q} + {1'b0, inc_q};

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        inc_d   = inc_q;
        count_d = count_q;
        ncyc_d  = ncyc_q;
        wave_d  = wave_q;
        inv_d   = inv_q;
        data_d  = MIDSCALE;
        ch_d    = 1'b0;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        code    = 8'h80;

        case (state_q)
            IDLE: begin
                if (start) begin
                    inc_d   = phase_inc;
                    ncyc_d  = n_cycles;
                    wave_d  = wave_sel;
                    inv_d   = ch_invert;
                    phase_d = '0;
                    count_d = '0;
                    state_d = (n_cycles == '0 || phase_inc == '0) ? PARK0 : EMIT0;
                end
            end
            EMIT0: if (xfer) state_d = EMIT1;
            EMIT1: begin
                if (xfer) begin
                    phase_d = phase_sum[PHASE_W-1:0];
                    state_d = EMIT0;
                    if (phase_sum[PHASE_W]) begin
                        count_d = count_q + CNT_W'(1);
                        if (count_d == ncyc_q) state_d = PARK0;
                    end
                end
            end
            PARK0: if (xfer) state_d = PARK1;
            PARK1: if (xfer) state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are registered, so derive them from the next state and phase.
        code    = shape(wave_d, phase_d[PHASE_W-1 -: 8]);
        valid_d = (state_d == EMIT0) || (state_d == EMIT1) ||
                  (state_d == PARK0) || (state_d == PARK1);
        busy_d  = valid_d;
        done_d  = (state_d == FIN);
        ch_d    = (state_d == EMIT1) || (state_d == PARK1);
        case (state_d)
            EMIT0:   data_d = SAMPLE_W'(code);
            EMIT1:   data_d = inv_d ? SAMPLE_W'(~code) : SAMPLE_W'(code);
            default: data_d = MIDSCALE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            phase_q <= '0;
            inc_q   <= '0;
            count_q <= '0;
            ncyc_q  <= '0;
            wave_q  <= '0;
            inv_q   <= 1'b0;
            data_q  <= MIDSCALE;
            ch_q    <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            inc_q   <= inc_d;
            count_q <= count_d;
            ncyc_q  <= ncyc_d;
            wave_q  <= wave_d;
            inv_q   <= inv_d;
            data_q  <= data_d;
            ch_q    <= ch_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign s.s_data  = data_q;
    assign s.s_ch    = ch_q;
    assign s.s_valid = valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
endmodule

// File: tb/tb_dac_burst_gen.sv
// Scoreboard bench for dac_burst_gen: expected words are queued at start, popped per transfer.
module tb_dac_burst_gen;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] phase_inc;
    logic [7:0]  n_cycles;
    logic [1:0]  wave_sel;
    logic        ch_invert;
    logic        busy;
    logic        done;

    dac_burst_gen_if #(.SAMPLE_W(8)) bus ();

    dac_burst_gen #(.PHASE_W(16), .SAMPLE_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .phase_inc (phase_inc),
        .n_cycles  (n_cycles),
        .wave_sel  (wave_sel),
        .ch_invert (ch_invert),
        .s         (bus),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    logic [8:0] exp_q[$];

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic int model_code(input int w, input int p);
        case (w)
            0:       return (p < 128) ? 255 : 0;
            1:       return (p < 128) ? 2 * p : 255 - 2 * (p - 128);
            2:       return p;
            default: return 128;
        endcase
    endfunction

    task automatic push_expected(input int w, input int inc, input int n, input bit inv);
        int ph = 0;
        int cnt = 0;
        int c;
        if (n != 0 && inc != 0) begin
            for (int k = 0; k < 20000; k++) begin
                c = model_code(w, ph / 256);
                exp_q.push_back({1'b0, 8'(c)});
                exp_q.push_back({1'b1, inv ? 8'(255 - c) : 8'(c)});
                ph = ph + inc;
                if (ph >= 65536) begin
                    ph = ph - 65536;
                    cnt++;
                    if (cnt == n) break;
                end
            end
        end
        exp_q.push_back({1'b0, 8'h80});
        exp_q.push_back({1'b1, 8'h80});
    endtask

    function automatic bit ready_at(input int mode, input int cyc);
        case (mode)
            0:       return 1'b1;
            1:       return (cyc % 3) == 0;
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    // Runs one burst; optionally pokes start mid-burst and during the done cycle.
    task automatic run_burst(input string name, input int w, input int inc, input int n,
                             input bit inv, input int rmode, input bit poke);
        bit         done_seen = 1'b0;
        bit         was_stall = 1'b0;
        logic [7:0] hd = 8'h0;
        logic       hc = 1'b0;
        int         xfers = 0;
        int         last_x = 0;
        int         total;
        logic [8:0] e;
        bit         rdy;

        exp_q.delete();
        push_expected(w, inc, n, inv);
        total = exp_q.size();
        wave_sel = 2'(w); phase_inc = 16'(inc); n_cycles = 8'(n); ch_invert = inv;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({name, "_busy_lat"}, int'(busy), 1);
        check({name, "_valid_lat"}, int'(bus.s_valid), 1);

        for (int cyc = 0; cyc < 5000; cyc++) begin
            if (done) begin
                done_seen = 1'b1;
                check({name, "_xfers"}, xfers, total);
                check({name, "_done_lat"}, cyc - last_x, 1);
                check({name, "_fin_busy"}, int'(busy), 0);
                check({name, "_fin_valid"}, int'(bus.s_valid), 0);
                if (poke) begin
                    start = 1'b1; phase_inc = 16'h0100; n_cycles = 8'd3;
                end
                break;
            end
            if (was_stall) begin
                check({name, "_hold_valid"}, int'(bus.s_valid), 1);
                check({name, "_hold_data"}, int'(bus.s_data), int'(hd));
                check({name, "_hold_ch"}, int'(bus.s_ch), int'(hc));
            end
            rdy = ready_at(rmode, cyc);
            bus.s_ready = rdy;
            if (bus.s_valid && rdy) begin
                if (exp_q.size() == 0) begin
                    check({name, "_extra_word"}, int'({bus.s_ch, bus.s_data}), -1);
                end else begin
                    e = exp_q.pop_front();
                    check({name, "_data"}, int'(bus.s_data), int'(e[7:0]));
                    check({name, "_ch"}, int'(bus.s_ch), int'(e[8]));
                end
                xfers++;
                last_x = cyc;
            end
            was_stall = bus.s_valid && !rdy;
            hd = bus.s_data;
            hc = bus.s_ch;
            if (poke && cyc == 3) begin
                start = 1'b1; wave_sel = 2'd0; phase_inc = 16'hFFFF; n_cycles = 8'd9; ch_invert = ~inv;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        if (!done_seen) check({name, "_timeout"}, 0, 1);
        @(posedge clk); #1;
        start = 1'b0;
        check({name, "_done_pulse"}, int'(done), 0);
        check({name, "_idle_valid"}, int'(bus.s_valid), 0);
        check({name, "_idle_busy"}, int'(busy), 0);
        check({name, "_queue_empty"}, exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; phase_inc = '0; n_cycles = '0; wave_sel = '0;
        ch_invert = 1'b0; bus.s_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", int'(bus.s_valid), 0);
        check("rst_data", int'(bus.s_data), 8'h80);
        check("rst_ch", int'(bus.s_ch), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_burst("tri",     1, 16'h4000, 1, 1'b0, 0, 1'b0);
        run_burst("tri_inv", 1, 16'h4000, 1, 1'b1, 0, 1'b0);
        run_burst("sq_bp",   0, 16'h8000, 2, 1'b0, 1, 1'b0);
        run_burst("n_zero",  2, 16'h1234, 0, 1'b0, 0, 1'b0);
        run_burst("inc_zero",1, 16'h0000, 5, 1'b0, 2, 1'b0);
        run_burst("dc_inv",  3, 16'h8000, 1, 1'b1, 2, 1'b0);
        run_burst("saw_poke",2, 16'h2000, 2, 1'b0, 2, 1'b1);
        run_burst("tri_big", 1, 16'h0C00, 3, 1'b1, 2, 1'b0);

        // Reset after the third transfer of a triangle burst, with start held to show rst wins.
        wave_sel = 2'd1; phase_inc = 16'h4000; n_cycles = 8'd1; ch_invert = 1'b0;
        bus.s_ready = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        check("mid_rst_valid", int'(bus.s_valid), 0);
        check("mid_rst_data", int'(bus.s_data), 8'h80);
        check("mid_rst_ch", int'(bus.s_ch), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_done", int'(done), 0);
        repeat (3) begin
            @(posedge clk); #1;
            check("post_rst_done", int'(done), 0);
            check("post_rst_valid", int'(bus.s_valid), 0);
        end
        run_burst("after_rst", 1, 16'h4000, 1, 1'b0, 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
